// File: rtl/aer_pkg.sv
// Shared types and helpers for the AER transmit scheduler: FSM state encoding,
// address width derivation and {channel, polarity} address packing.
package aer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } aer_state_e;

  // One address bit per channel-index bit plus one polarity bit.
  function automatic int aer_addr_width(input int nch);
    return $clog2(nch) + 1;
  endfunction

  // Source index and bus address share the same {ch, pol} packing.
  function automatic int aer_pack_addr(input int ch, input logic pol);
    return 2 * ch + int'(pol);
  endfunction

endpackage

// File: rtl/aer_rr_picker.sv
// Combinational round-robin search: first pending source at rr, rr+1, ...
// with wrap-around.
module aer_rr_picker
  import aer_pkg::*;
#(
  parameter int NS = 4,
  parameter int IW = 2
) (
  input  logic [NS-1:0] pending,
  input  logic [IW-1:0] rr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  // NOTE: every output gets a default before the search so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    // Upper segment first: indices at or above the pointer.
    for (int i = 0; i < NS; i++) begin
      if (!gnt_valid && pending[i] && (IW'(i) >= rr)) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(i);
      end
    end
    // Nothing at or above rr: the wrapped answer is the lowest pending index.
    for (int i = 0; i < NS; i++) begin
      if (!gnt_valid && pending[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/aer_tx_scheduler.sv
// Synchronous AER transmit scheduler: latches up/down spike edges per channel
// and serves them round-robin over one 4-phase req/ack link.
module aer_tx_scheduler
  import aer_pkg::*;
#(
  parameter  int NCH     = 2,
  parameter  int TIMEOUT = 1024,
  parameter  int CW      = 8,
  localparam int AW      = aer_addr_width(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] up_in,
  input  logic [NCH-1:0] down_in,
  input  logic           aer_ack,
  output logic           aer_req,
  output logic [AW-1:0]  aer_addr,
  output logic           busy,
  output logic           timeout_err,
  output logic [CW-1:0]  drop_count
);

  localparam int NS = 2 * NCH;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [NCH-1:0] up_meta_q, up_sync_q, up_prev_q;
  logic [NCH-1:0] dn_meta_q, dn_sync_q, dn_prev_q;
  logic           ack_meta_q, ack_sync_q;

  aer_state_e     state_q, state_d;
  logic [NS-1:0]  pending_q, pending_d;
  logic [AW-1:0]  rr_q, rr_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           req_q, req_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           terr_q, terr_d;
  logic [CW-1:0]  drop_q, drop_d;

  logic [NS-1:0]  src_rise, grant_mask, overrun;
  logic           gnt_valid;
  logic [AW-1:0]  gnt_idx, next_rr;
  logic           timer_done;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, as the synchronizer chain relies on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_meta_q  <= '0;
      up_sync_q  <= '0;
      up_prev_q  <= '0;
      dn_meta_q  <= '0;
      dn_sync_q  <= '0;
      dn_prev_q  <= '0;
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      up_meta_q  <= up_in;
      up_sync_q  <= up_meta_q;
      up_prev_q  <= up_sync_q;
      dn_meta_q  <= down_in;
      dn_sync_q  <= dn_meta_q;
      dn_prev_q  <= dn_sync_q;
      ack_meta_q <= aer_ack;
      ack_sync_q <= ack_meta_q;
    end
  end

  always_comb begin
    src_rise = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      src_rise[aer_pack_addr(ch, 1'b1)] = up_sync_q[ch] & ~up_prev_q[ch];
      src_rise[aer_pack_addr(ch, 1'b0)] = dn_sync_q[ch] & ~dn_prev_q[ch];
    end
  end

  aer_rr_picker #(
    .NS (NS),
    .IW (AW)
  ) u_picker (
    .pending   (pending_q),
    .rr        (rr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // A rise on the source being granted this cycle re-arms it instead of
  // counting as an overrun.
  always_comb begin
    grant_mask = '0;
    if (state_q == IDLE && gnt_valid) grant_mask = NS'(1) << gnt_idx;
    overrun   = src_rise & pending_q & ~grant_mask;
    pending_d = (pending_q & ~grant_mask) | src_rise;
    drop_d    = drop_q;
    for (int s = 0; s < NS; s++) begin
      if (overrun[s] && drop_d != '1) drop_d = drop_d + 1'b1;
    end
  end

  assign next_rr    = (addr_q == AW'(NS - 1)) ? '0 : addr_q + 1'b1;
  // timer_q counts completed waiting cycles; TIMEOUT-1 here means this is the
  // TIMEOUT-th cycle spent in the current phase.
  assign timer_done = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req_d   = req_q;
    timer_d = timer_q;
    rr_d    = rr_q;
    terr_d  = terr_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          addr_d  = gnt_idx;
          state_d = SETUP;
        end
      end
      SETUP: begin
        req_d   = 1'b1;
        timer_d = '0;
        state_d = REQ;
      end
      REQ: begin
        if (ack_sync_q) begin
          req_d   = 1'b0;
          timer_d = '0;
          state_d = RELEASE;
        end else if (timer_done) begin
          req_d   = 1'b0;
          terr_d  = 1'b1;
          rr_d    = next_rr;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!ack_sync_q || timer_done) begin
          terr_d  = terr_q | ack_sync_q;
          rr_d    = next_rr;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_q      <= '0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      timer_q   <= '0;
      terr_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      timer_q   <= timer_d;
      terr_q    <= terr_d;
      drop_q    <= drop_d;
    end
  end

  assign aer_req     = req_q;
  assign aer_addr    = addr_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_aer_tx_scheduler.sv
// Self-checking bench for aer_tx_scheduler: directed corner sequences, a
// round-robin vector table and a randomized token scoreboard.
module tb_aer_tx_scheduler;

  logic       clk;
  logic       reset;
  logic [1:0] up_in;
  logic [1:0] down_in;
  logic       aer_ack;
  logic       aer_req;
  logic [1:0] aer_addr;
  logic       busy;
  logic       timeout_err;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic       ack_auto;
  logic       ack_manual;
  int         ack_lat;
  logic [1:0] seen_q[$];

  typedef struct {
    logic [3:0] mask;
    int         n;
    logic [7:0] seq;
  } vec_t;
  vec_t tbl[7];

  aer_tx_scheduler #(
    .NCH     (2),
    .TIMEOUT (16),
    .CW      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .up_in       (up_in),
    .down_in     (down_in),
    .aer_ack     (aer_ack),
    .aer_req     (aer_req),
    .aer_addr    (aer_addr),
    .busy        (busy),
    .timeout_err (timeout_err),
    .drop_count  (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Source index s = 2*ch + pol, pol 1 = up.
  task automatic set_src(input int s, input logic v);
    if (s % 2 == 1) up_in[s / 2] = v;
    else            down_in[s / 2] = v;
  endtask

  task automatic wait_req(input logic lvl, input int budget);
    int n = 0;
    while (aer_req !== lvl && n < budget) begin
      tick(1);
      n++;
    end
    check($sformatf("wait_req_%0d", lvl), aer_req, lvl);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check("wait_idle", busy, 0);
  endtask

  task automatic wait_events(input int n, input int budget);
    int k = 0;
    while (seen_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check("event_count", seen_q.size(), n);
  endtask

  task automatic expect_event(input string name, input logic [1:0] exp);
    if (seen_q.size() > 0) check(name, seen_q.pop_front(), exp);
    else check({name, "_missing"}, 0, 1);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    up_in      = '0;
    down_in    = '0;
    ack_auto   = 1'b0;
    ack_manual = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(3);
    seen_q.delete();
  endtask

  // Receiver model: ack follows req after ack_lat sampled cycles, or a manual level.
  initial begin
    logic [7:0] hist;
    hist    = '0;
    aer_ack = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      hist    = {hist[6:0], aer_req};
      aer_ack = ack_auto ? hist[ack_lat-1] : ack_manual;
    end
  end

  // Bus monitor: logs each request and checks address setup and stability.
  initial begin
    logic       prev_req;
    logic [1:0] prev_addr;
    prev_req  = 1'b0;
    prev_addr = '0;
    forever begin
      @(posedge clk);
      #2;
      if (aer_req && !prev_req) begin
        check("addr_before_req", aer_addr, prev_addr);
        seen_q.push_back(aer_addr);
      end else if (aer_req && prev_req) begin
        check("addr_stable", aer_addr, prev_addr);
      end
      prev_req  = aer_req;
      prev_addr = aer_addr;
    end
  end

  initial begin
    int n;
    int raised[4];
    int sent[4];
    int outst[4];
    int hold[4];
    logic lvl[4];

    // Expected orders derived by hand from the pointer rules; rr carries over.
    tbl[0] = '{4'b1111, 4, 8'hE4};  // rr 0: 0,1,2,3 -> rr 0
    tbl[1] = '{4'b1001, 2, 8'h0C};  // rr 0: 0,3     -> rr 0
    tbl[2] = '{4'b0100, 1, 8'h02};  // rr 0: 2       -> rr 3
    tbl[3] = '{4'b1001, 2, 8'h03};  // rr 3: 3,0     -> rr 1
    tbl[4] = '{4'b0101, 2, 8'h02};  // rr 1: 2,0     -> rr 1
    tbl[5] = '{4'b0011, 2, 8'h01};  // rr 1: 1,0     -> rr 1
    tbl[6] = '{4'b1010, 2, 8'h0D};  // rr 1: 1,3     -> rr 0

    reset      = 1'b1;
    up_in      = '0;
    down_in    = '0;
    ack_auto   = 1'b0;
    ack_manual = 1'b0;
    ack_lat    = 2;
    tick(2);
    check("rst_req", aer_req, 0);
    check("rst_addr", aer_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_drop", drop_count, 0);
    reset = 1'b0;
    tick(3);

    // Single event on down_in[1] -> address 2'b10.
    ack_auto = 1'b1;
    set_src(2, 1'b1);
    n = 0;
    while (aer_addr !== 2'b10 && n < 20) begin
      tick(1);
      n++;
    end
    check("single_addr_valid", aer_addr, 2'b10);
    n = 0;
    while (!aer_req && n < 20) begin
      tick(1);
      n++;
    end
    check("single_req_delay", n, 1);
    set_src(2, 1'b0);
    wait_events(1, 50);
    expect_event("single_addr", 2'b10);
    wait_req(1'b0, 30);
    wait_idle(30);
    check("single_drop", drop_count, 0);

    // Round-robin table.
    do_reset();
    ack_auto = 1'b1;
    for (int v = 0; v < 7; v++) begin
      for (int s = 0; s < 4; s++) if (tbl[v].mask[s]) set_src(s, 1'b1);
      tick(3);
      up_in   = '0;
      down_in = '0;
      wait_events(tbl[v].n, 400);
      for (int i = 0; i < tbl[v].n; i++) begin
        logic [7:0] sq;
        sq = tbl[v].seq;
        expect_event($sformatf("tbl%0d_ev%0d", v, i), sq[2*i +: 2]);
      end
      wait_idle(100);
      tick(4);
    end
    check("tbl_drop", drop_count, 0);

    // Overrun: s=1 gets two edges while s=0 stalls in REQ.
    do_reset();
    set_src(0, 1'b1);
    wait_req(1'b1, 20);
    set_src(1, 1'b1); tick(2);
    set_src(1, 1'b0); tick(2);
    set_src(1, 1'b1); tick(2);
    set_src(1, 1'b0); tick(2);
    check("ovr_drop", drop_count, 1);
    ack_auto = 1'b1;
    wait_events(2, 200);
    expect_event("ovr_first", 2'd0);
    expect_event("ovr_second", 2'd1);
    tick(40);
    check("ovr_no_extra", seen_q.size(), 0);
    check("ovr_drop_final", drop_count, 1);
    check("ovr_terr", timeout_err, 0);
    set_src(0, 1'b0);

    // Same-cycle re-arm: second s=3 rise lands on the IDLE cycle granting s=3.
    do_reset();
    set_src(0, 1'b1);
    wait_req(1'b1, 20);
    set_src(3, 1'b1); tick(2);
    set_src(3, 1'b0); tick(2);
    ack_manual = 1'b1;
    wait_req(1'b0, 20);
    ack_manual = 1'b0;
    tick(1);
    set_src(3, 1'b1); tick(2);
    set_src(3, 1'b0);
    ack_auto = 1'b1;
    wait_events(3, 300);
    expect_event("rearm_ev0", 2'd0);
    expect_event("rearm_ev1", 2'd3);
    expect_event("rearm_ev2", 2'd3);
    check("rearm_drop", drop_count, 0);
    tick(30);
    check("rearm_no_extra", seen_q.size(), 0);
    set_src(0, 1'b0);

    // Timeout with ack stuck low; s=3 queued behind.
    do_reset();
    set_src(0, 1'b1);
    wait_req(1'b1, 20);
    check("to_terr_before", timeout_err, 0);
    n = 0;
    while (aer_req && n < 40) begin
      if (n == 0) set_src(3, 1'b1);
      if (n == 3) set_src(3, 1'b0);
      tick(1);
      n++;
    end
    check("to_req_cycles", n, 16);
    check("to_terr", timeout_err, 1);
    wait_req(1'b1, 10);
    check("to_next_addr", aer_addr, 2'd3);
    wait_req(1'b0, 30);
    wait_idle(10);
    expect_event("to_ev0", 2'd0);
    expect_event("to_ev1", 2'd3);
    set_src(0, 1'b0);

    // Asynchronous reset mid-handshake.
    set_src(1, 1'b1);
    wait_req(1'b1, 20);
    check("mid_terr_before", timeout_err, 1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_req", aer_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", aer_addr, 0);
    check("mid_rst_terr", timeout_err, 0);
    check("mid_rst_drop", drop_count, 0);
    set_src(1, 1'b0);
    tick(3);
    reset = 1'b0;
    seen_q.delete();
    ack_auto = 1'b1;
    tick(40);
    check("mid_no_stale", seen_q.size(), 0);
    check("mid_busy_after", busy, 0);

    // Randomized traffic against a token scoreboard: each rising edge on an
    // idle source must produce exactly one transfer of that source.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      raised[s] = 0;
      sent[s]   = 0;
      outst[s]  = 0;
      hold[s]   = 2;
      lvl[s]    = 1'b0;
    end
    for (int seg = 0; seg < 3; seg++) begin
      ack_lat  = int'($urandom_range(1, 4));
      ack_auto = 1'b1;
      for (int c = 0; c < 600; c++) begin
        for (int s = 0; s < 4; s++) begin
          if (lvl[s]) begin
            if (hold[s] >= 2 && $urandom_range(0, 2) == 0) begin
              set_src(s, 1'b0);
              lvl[s]  = 1'b0;
              hold[s] = 0;
            end
          end else if (hold[s] >= 2 && outst[s] == 0 && $urandom_range(0, 5) == 0) begin
            set_src(s, 1'b1);
            lvl[s]  = 1'b1;
            hold[s] = 0;
            outst[s]++;
            raised[s]++;
          end
          hold[s]++;
        end
        tick(1);
        while (seen_q.size() > 0) begin
          logic [1:0] a;
          a = seen_q.pop_front();
          check("rnd_expected_src", outst[a] > 0, 1);
          if (outst[a] > 0) outst[a]--;
          sent[a]++;
        end
      end
      up_in   = '0;
      down_in = '0;
      for (int s = 0; s < 4; s++) begin
        lvl[s]  = 1'b0;
        hold[s] = 2;
      end
      n = 0;
      while ((outst[0] + outst[1] + outst[2] + outst[3] > 0 || busy) && n < 2000) begin
        tick(1);
        n++;
        while (seen_q.size() > 0) begin
          logic [1:0] a;
          a = seen_q.pop_front();
          check("rnd_expected_src", outst[a] > 0, 1);
          if (outst[a] > 0) outst[a]--;
          sent[a]++;
        end
      end
      check($sformatf("rnd_drain_seg%0d", seg), outst[0] + outst[1] + outst[2] + outst[3], 0);
      tick(10);
    end
    for (int s = 0; s < 4; s++) check($sformatf("rnd_count_s%0d", s), sent[s], raised[s]);
    check("rnd_drop", drop_count, 0);
    check("rnd_terr", timeout_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
